rdbuf_drain: RTL and testbench



---
 rtl/rdbuf_drain_pkg.sv | 23 ++
 rtl/rdbuf_drain_fifo.sv | 70 +++++++
 rtl/rdbuf_drain.sv | 206 ++++++++++++++++++++
 tb/tb_rdbuf_drain.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rdbuf_drain_pkg.sv
// rdbuf_drain_pkg
// Shared types and constants for the read-buffer drain engine:
//   - u8_t / u9_t / u64_t : common word/counter types
//   - AXI_RESP_*          : AXI write-response encodings
//   - drain_state_e       : drain FSM states
package rdbuf_drain_pkg;

  typedef logic [7:0]  u8_t;
  typedef logic [8:0]  u9_t;
  typedef logic [63:0] u64_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_RESP,
    ST_FIN
  } drain_state_e;

endpackage

// File: rtl/rdbuf_drain_fifo.sv
// rdbuf_drain_fifo
// Small synchronous FIFO holding prefetched buffer words ahead of the W channel.
// Ports:
//   clk_i, xrst_i      clock, asynchronous active-low reset
//   push_i, data_i     write strobe and data
//   pop_i              read strobe (head advances)
//   data_o             current head entry
//   empty_o            no entries stored
//   count_o            number of stored entries
module rdbuf_drain_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             xrst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (push_i) wrPtr_d = nextPtr(wrPtr_q);
    if (pop_i)  rdPtr_d = nextPtr(rdPtr_q);
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge xrst_i) begin
    if (!xrst_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wrPtr_q] <= data_i;
  end

  assign data_o  = mem_q[rdPtr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/rdbuf_drain.sv
// rdbuf_drain
// Reads the output buffer's 64-bit port A sequentially and streams the words
// to DDR as AXI4 INCR write bursts, one burst outstanding at a time.
// Ports:
//   clk_i, xrst_i                clock, asynchronous active-low reset
//   start_i, base_i, nwords_i    job kick, DDR base address, word count (0..256)
//   busy_o, done_o, err_o        job status; err_o is sticky until next start
//   buf_addr_o, buf_dout_i       buffer port-A address / read data
//   aw*_o/_i, w*_o/_i, b*_o/_i   AXI4 write address, data and response channels
module rdbuf_drain
  import rdbuf_drain_pkg::*;
#(
  parameter int BURST_LEN  = 16,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        xrst_i,
  input  logic        start_i,
  input  logic [31:0] base_i,
  input  u9_t         nwords_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output u8_t         buf_addr_o,
  input  u64_t        buf_dout_i,
  output logic [31:0] awaddr_o,
  output u8_t         awlen_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output u64_t        wdata_o,
  output logic [7:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o
);

  localparam int         CNT_W       = $clog2(FIFO_DEPTH + 1);
  localparam u9_t        BURST_WORDS = u9_t'(BURST_LEN);
  localparam logic [7:0] DEPTH_W     = 8'(FIFO_DEPTH);

  drain_state_e      state_q, state_d;
  logic [31:0]       base_q, base_d;
  u9_t               nwords_q, nwords_d;
  u9_t               sent_q, sent_d;
  u9_t               rdIssued_q, rdIssued_d;
  u8_t               beat_q, beat_d;
  u8_t               awlen_q, awlen_d;
  logic              err_q, err_d;
  logic [RD_LAT-1:0] vld_q, vld_d;

  u9_t               remaining, burstWords;
  u8_t               curLen;
  logic [7:0]        inFlight;
  logic              prefetchOn, issue, wHandshake;
  logic              fifoEmpty;
  logic [CNT_W-1:0]  fifoCount;
  u64_t              fifoHead;

  rdbuf_drain_fifo #(
    .WIDTH (64),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i   (clk_i),
    .xrst_i  (xrst_i),
    .push_i  (vld_q[RD_LAT-1]),
    .data_i  (buf_dout_i),
    .pop_i   (wHandshake),
    .data_o  (fifoHead),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  // Burst sizing and the prefetch engine. A read is issued only when the
  // FIFO plus the reads still in the latency pipeline cannot overflow, so a
  // pushed word always finds a free slot.
  always_comb begin
    remaining  = nwords_q - sent_q;
    burstWords = (remaining > BURST_WORDS) ? BURST_WORDS : remaining;
    curLen     = u8_t'(burstWords - 9'd1);

    inFlight = '0;
    for (int i = 0; i < RD_LAT; i++) inFlight = inFlight + 8'(vld_q[i]);

    prefetchOn = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_RESP);
    issue      = prefetchOn && (rdIssued_q < nwords_q) &&
                 ((8'(fifoCount) + inFlight) < DEPTH_W);

    vld_d[0] = issue;
    for (int i = 1; i < RD_LAT; i++) vld_d[i] = vld_q[i-1];
  end

  // Drain FSM: next state plus all AXI/status outputs, defaults first.
  // An empty job still passes through ADDR for one busy cycle (without
  // raising awvalid), so its done pulse lands two cycles after start.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    nwords_d   = nwords_q;
    sent_d     = sent_q;
    rdIssued_d = rdIssued_q + u9_t'(issue);
    beat_d     = beat_q;
    awlen_d    = awlen_q;
    err_d      = err_q;
    wHandshake = 1'b0;
    busy_o     = 1'b0;
    done_o     = 1'b0;
    awvalid_o  = 1'b0;
    awaddr_o   = '0;
    awlen_o    = '0;
    wvalid_o   = 1'b0;
    wdata_o    = '0;
    wstrb_o    = '0;
    wlast_o    = 1'b0;
    bready_o   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          base_d     = base_i;
          nwords_d   = nwords_i;
          err_d      = 1'b0;
          sent_d     = '0;
          rdIssued_d = '0;
          beat_d     = '0;
          state_d    = ST_ADDR;
        end
      end
      ST_ADDR: begin
        busy_o = 1'b1;
        if (remaining == '0) begin
          state_d = ST_FIN;
        end else begin
          awvalid_o = 1'b1;
          awaddr_o  = base_q + {20'd0, sent_q, 3'd0};
          awlen_o   = curLen;
          if (awready_i) begin
            awlen_d = curLen;
            beat_d  = '0;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        busy_o   = 1'b1;
        wvalid_o = !fifoEmpty;
        if (wvalid_o) begin
          wdata_o = fifoHead;
          wstrb_o = 8'hFF;
          wlast_o = (beat_q == awlen_q);
        end
        wHandshake = wvalid_o && wready_i;
        if (wHandshake) begin
          sent_d = sent_q + 9'd1;
          beat_d = beat_q + 8'd1;
          if (wlast_o) state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        busy_o   = 1'b1;
        bready_o = 1'b1;
        if (bvalid_i) begin
          if (bresp_i != AXI_RESP_OKAY) err_d = 1'b1;
          state_d = (sent_q == nwords_q) ? ST_FIN : ST_ADDR;
        end
      end
      ST_FIN: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge xrst_i) begin
    if (!xrst_i) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      nwords_q   <= '0;
      sent_q     <= '0;
      rdIssued_q <= '0;
      beat_q     <= '0;
      awlen_q    <= '0;
      err_q      <= 1'b0;
      vld_q      <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      nwords_q   <= nwords_d;
      sent_q     <= sent_d;
      rdIssued_q <= rdIssued_d;
      beat_q     <= beat_d;
      awlen_q    <= awlen_d;
      err_q      <= err_d;
      vld_q      <= vld_d;
    end
  end

  assign err_o      = err_q;
  assign buf_addr_o = rdIssued_q[7:0];

endmodule

// File: tb/tb_rdbuf_drain.sv
// tb_rdbuf_drain
// Directed bench for rdbuf_drain: a two-stage buffer model, AXI slave
// responders, a negedge monitor that logs handshakes, and directed jobs.
module tb_rdbuf_drain;
  import rdbuf_drain_pkg::*;

  localparam int BURST_LEN  = 16;
  localparam int RD_LAT     = 2;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        xrst, start;
  logic [31:0] base;
  u9_t         nwords;
  logic        busy, done, err;
  u8_t         bufAddr;
  u64_t        bufDout = '0;
  logic [31:0] awaddr;
  u8_t         awlen;
  logic        awvalid, awready = 1'b0;
  u64_t        wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bvalid = 1'b0, bready;

  int total = 0;
  int bad   = 0;

  // Set by the directed sequence only.
  logic randomMode;
  int   errBurst;

  // Written by the monitor/responder process only.
  logic [31:0] awAddrLog[$];
  u8_t         awLenLog[$];
  u64_t        dataLog[$];
  logic        lastLog[$];
  int          doneCount, busyCycles, protoErr, bCount, awCnt, awWait;
  logic        wStallPrev, awStallPrev, bHs, wLastHs, lastPrev;
  u64_t        wdPrev;
  logic [31:0] aaPrev;
  u8_t         alPrev;

  logic busyT1, awvT1, errT1;

  always #5 clk = ~clk;

  rdbuf_drain #(
    .BURST_LEN  (BURST_LEN),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i      (clk),
    .xrst_i     (xrst),
    .start_i    (start),
    .base_i     (base),
    .nwords_i   (nwords),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .buf_addr_o (bufAddr),
    .buf_dout_i (bufDout),
    .awaddr_o   (awaddr),
    .awlen_o    (awlen),
    .awvalid_o  (awvalid),
    .awready_i  (awready),
    .wdata_o    (wdata),
    .wstrb_o    (wstrb),
    .wlast_o    (wlast),
    .wvalid_o   (wvalid),
    .wready_i   (wready),
    .bresp_i    (bresp),
    .bvalid_i   (bvalid),
    .bready_o   (bready)
  );

  function automatic u64_t wordOf(input int i);
    return {32'hA5A5_0000 + 32'(i), 32'(i)};
  endfunction

  // Buffer port A with two cycles from address to data.
  u64_t rdPipe = '0;
  always @(posedge clk) begin
    rdPipe  <= wordOf(int'(bufAddr));
    bufDout <= rdPipe;
  end

  // Monitor at negedge, then drive slave-side ready/response after posedge.
  always begin
    @(negedge clk);
    if (!xrst) begin
      awAddrLog.delete(); awLenLog.delete(); dataLog.delete(); lastLog.delete();
      doneCount = 0; busyCycles = 0; protoErr = 0; bCount = 0;
      wStallPrev = 1'b0; awStallPrev = 1'b0; bHs = 1'b0; wLastHs = 1'b0;
    end else begin
      if (start && !busy && !done) begin
        awAddrLog.delete(); awLenLog.delete(); dataLog.delete(); lastLog.delete();
        doneCount = 0; busyCycles = 0; protoErr = 0; bCount = 0;
      end
      if (wStallPrev && !(wvalid && wdata === wdPrev && wlast === lastPrev)) protoErr++;
      if (awStallPrev && !(awvalid && awaddr === aaPrev && awlen === alPrev)) protoErr++;
      if (wvalid && wstrb !== 8'hFF) protoErr++;
      wStallPrev  = wvalid && !wready;
      awStallPrev = awvalid && !awready;
      wdPrev = wdata; lastPrev = wlast; aaPrev = awaddr; alPrev = awlen;
      if (awvalid && awready) begin
        awAddrLog.push_back(awaddr);
        awLenLog.push_back(awlen);
      end
      if (wvalid && wready) begin
        dataLog.push_back(wdata);
        lastLog.push_back(wlast);
      end
      if (done) doneCount++;
      if (busy) busyCycles++;
      bHs     = bvalid && bready;
      wLastHs = wvalid && wready && wlast;
    end
    @(posedge clk);
    #1;
    if (!xrst) begin
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = AXI_RESP_OKAY;
      awCnt = 0; awWait = 0;
    end else begin
      if (!randomMode) awready = 1'b1;
      else if (!awvalid) begin
        awready = 1'b0; awCnt = 0; awWait = int'($urandom_range(0, 5));
      end else begin
        awready = (awCnt >= awWait);
        awCnt++;
      end
      wready = randomMode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bHs) begin bvalid = 1'b0; bresp = AXI_RESP_OKAY; end
      if (wLastHs) begin
        bvalid = 1'b1;
        bresp  = (bCount == errBurst) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        bCount++;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns in cycle T+1 with its status captured.
  task automatic applyStimulus(input logic [31:0] b, input int n);
    base = b; nwords = u9_t'(n); start = 1'b1;
    @(posedge clk); #1;
    busyT1 = busy; awvT1 = awvalid; errT1 = err;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag);
    int c = 0;
    while (doneCount == 0 && c < 20000) begin
      @(posedge clk); #1;
      c++;
    end
    checkOutput(tag, 64'(doneCount != 0), 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic checkJob(input string tag, input logic [31:0] b, input int n, input logic expErr);
    int bursts = (n + BURST_LEN - 1) / BURST_LEN;
    checkOutput({tag, "_aw_count"}, 64'(awAddrLog.size()), 64'(bursts));
    for (int k = 0; k < bursts && k < awAddrLog.size(); k++) begin
      int rem = n - k * BURST_LEN;
      checkOutput({tag, "_awaddr"}, 64'(awAddrLog[k]), 64'(b + 32'(k * BURST_LEN * 8)));
      checkOutput({tag, "_awlen"}, 64'(awLenLog[k]), 64'(((rem > BURST_LEN) ? BURST_LEN : rem) - 1));
    end
    checkOutput({tag, "_beat_count"}, 64'(dataLog.size()), 64'(n));
    for (int i = 0; i < n && i < dataLog.size(); i++) begin
      checkOutput({tag, "_wdata"}, dataLog[i], wordOf(i));
      checkOutput({tag, "_wlast"}, 64'(lastLog[i]), 64'((i % BURST_LEN == BURST_LEN - 1) || (i == n - 1)));
    end
    checkOutput({tag, "_err"}, 64'(err), 64'(expErr));
    checkOutput({tag, "_done_count"}, 64'(doneCount), 64'd1);
    checkOutput({tag, "_protocol"}, 64'(protoErr), 64'd0);
  endtask

  initial begin
    xrst = 1'b0; start = 1'b0; base = '0; nwords = '0;
    randomMode = 1'b0; errBurst = -1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ctrl", 64'({busy, done, err, awvalid, wvalid, wlast, bready}), 64'd0);
    checkOutput("rst_bufaddr", 64'(bufAddr), 64'd0);
    checkOutput("rst_aw", {awaddr, 24'd0, awlen}, 64'd0);
    checkOutput("rst_w", wdata | 64'(wstrb), 64'd0);
    xrst = 1'b1;
    @(posedge clk); #1;

    // Single full burst.
    applyStimulus(32'h1000_0000, 16);
    checkOutput("j16_busy_t1", 64'(busyT1), 64'd1);
    checkOutput("j16_awvalid_t1", 64'(awvT1), 64'd1);
    waitDone("j16_done_seen");
    checkJob("j16", 32'h1000_0000, 16, 1'b0);

    // Three bursts, last one partial.
    applyStimulus(32'h2000_0000, 40);
    waitDone("j40_done_seen");
    checkJob("j40", 32'h2000_0000, 40, 1'b0);
    checkOutput("j40_aw2_addr", 64'((awAddrLog.size() > 2) ? awAddrLog[2] : 32'd0), 64'h2000_0100);
    checkOutput("j40_aw2_len", 64'((awLenLog.size() > 2) ? awLenLog[2] : 8'd0), 64'd7);

    // Full buffer under random W backpressure and delayed AW ready.
    randomMode = 1'b1;
    applyStimulus(32'h3000_0000, 256);
    waitDone("j256_done_seen");
    checkJob("j256", 32'h3000_0000, 256, 1'b0);
    randomMode = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // SLVERR on the second burst; the next accepted start clears err.
    errBurst = 1;
    applyStimulus(32'h4000_0000, 32);
    waitDone("jerr_done_seen");
    checkJob("jerr", 32'h4000_0000, 32, 1'b1);
    errBurst = -1;
    applyStimulus(32'h4800_0000, 16);
    checkOutput("jclr_err_t1", 64'(errT1), 64'd0);
    waitDone("jclr_done_seen");
    checkJob("jclr", 32'h4800_0000, 16, 1'b0);

    // Empty job: busy only at T+1, done at T+2, no address phase.
    applyStimulus(32'h7000_0000, 0);
    checkOutput("j0_busy_t1", 64'(busyT1), 64'd1);
    checkOutput("j0_awvalid_t1", 64'(awvT1), 64'd0);
    @(posedge clk); #1;
    checkOutput("j0_done_t2", 64'({done, busy}), 64'b10);
    @(posedge clk); #1;
    checkOutput("j0_done_t3", 64'({done, busy}), 64'b00);
    checkOutput("j0_busy_cycles", 64'(busyCycles), 64'd1);
    checkOutput("j0_aw_count", 64'(awAddrLog.size()), 64'd0);

    // Asynchronous reset in the middle of burst 2, then a clean job.
    applyStimulus(32'h5000_0000, 40);
    begin
      int c = 0;
      while (dataLog.size() < 20 && c < 2000) begin
        @(posedge clk); #1;
        c++;
      end
    end
    checkOutput("jrst_mid_burst2", 64'(dataLog.size() >= 20 && dataLog.size() < 32), 64'd1);
    #2;
    xrst = 1'b0;
    #1;
    checkOutput("jrst_ctrl", 64'({busy, done, err, awvalid, wvalid, wlast, bready}), 64'd0);
    checkOutput("jrst_bufaddr", 64'(bufAddr), 64'd0);
    checkOutput("jrst_data", wdata | 64'(wstrb) | 64'(awaddr) | 64'(awlen), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    xrst = 1'b1;
    @(posedge clk); #1;
    applyStimulus(32'h6000_0000, 16);
    waitDone("jpost_done_seen");
    checkJob("jpost", 32'h6000_0000, 16, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
